// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants and types for the register scoreboard
package sb_pkg;
  localparam int NREG = 32;
  localparam int LATW = 3;
  localparam logic [LATW-1:0] LAT_VAR = 3'd7;

  typedef logic [4:0]      reg_idx_t;
  typedef logic [LATW-1:0] lat_t;
endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - per-register in-flight latency counter
module sb_entry
  import sb_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ld,
  input  logic [LATW-1:0] ld_val,
  input  logic            var_clr,
  output logic [LATW-1:0] cnt,
  output logic            busy
);

  lat_t cnt_q, cnt_d;

  // Load wins over the variable-latency clear; LAT_VAR never counts down.
  always_comb begin
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (var_clr) begin
      cnt_d = '0;
    end else if (cnt_q != '0 && cnt_q != LAT_VAR) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register scoreboard and issue stall controller
module reg_scoreboard
  import sb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        IssueValid,
  input  logic [4:0]  IssueRs,
  input  logic [4:0]  IssueRt,
  input  logic        IssueUseRs,
  input  logic        IssueUseRt,
  input  logic        IssueWb,
  input  logic [4:0]  IssueRd,
  input  logic [2:0]  IssueLat,
  input  logic        VarDone,
  input  logic [4:0]  VarRd,
  output logic        Stall,
  output logic        Issued,
  output logic [31:0] BusyMask,
  output logic [15:0] StallCount
);

  logic [NREG-1:0] busy;
  logic            hazard;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  assign busy[0] = 1'b0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_entry
      lat_t cnt;
      logic ld, var_clr;

      assign ld      = Issued && IssueWb && (IssueRd == reg_idx_t'(r));
      assign var_clr = VarDone && (VarRd == reg_idx_t'(r)) && (cnt == LAT_VAR);

      sb_entry u_entry (
        .clk    (clk),
        .reset  (reset),
        .ld     (ld),
        .ld_val (IssueLat),
        .var_clr(var_clr),
        .cnt    (cnt),
        .busy   (busy[r])
      );
    end
  endgenerate

  assign hazard = (IssueUseRs && busy[IssueRs]) ||
                  (IssueUseRt && busy[IssueRt]) ||
                  (IssueWb    && busy[IssueRd]);

  assign Stall    = IssueValid && hazard;
  assign Issued   = IssueValid && !hazard;
  assign BusyMask = busy;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule
